// File: rtl/mips_ctrl_output_decoder_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle 8-bit MIPS controller output decoder:
//   - 4-bit controller state codes (FETCH1..ADDIWR)
//   - PC source, ALU B select and ALU operation encodings
//   - one-hot instruction-register byte enables
//   - ctrl_t, the bundle of datapath control strobes
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package mips_ctrl_pkg;

    // Controller state codes; 0 and 15 are unused.
    localparam logic [3:0] FETCH1  = 4'd1;
    localparam logic [3:0] FETCH2  = 4'd2;
    localparam logic [3:0] FETCH3  = 4'd3;
    localparam logic [3:0] FETCH4  = 4'd4;
    localparam logic [3:0] DECODE  = 4'd5;
    localparam logic [3:0] MEMADR  = 4'd6;
    localparam logic [3:0] LBRD    = 4'd7;
    localparam logic [3:0] LBWR    = 4'd8;
    localparam logic [3:0] SBWR    = 4'd9;
    localparam logic [3:0] RTYPEEX = 4'd10;
    localparam logic [3:0] RTYPEWR = 4'd11;
    localparam logic [3:0] BEQEX   = 4'd12;
    localparam logic [3:0] JEX     = 4'd13;
    localparam logic [3:0] ADDIWR  = 4'd14;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
    localparam logic [1:0] ALUSRCB_ONE   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Instruction register byte enables
    localparam logic [3:0] IRWRITE_NONE = 4'b0000;
    localparam logic [3:0] IRWRITE_B0   = 4'b0001;
    localparam logic [3:0] IRWRITE_B1   = 4'b0010;
    localparam logic [3:0] IRWRITE_B2   = 4'b0100;
    localparam logic [3:0] IRWRITE_B3   = 4'b1000;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [3:0] irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_output_decoder_if.sv
// ---------------------------------------------------------------------------
// mips_ctrl_output_decoder_if
// Bus between the controller state register, the output decoder and the
// datapath.
//   state    : current controller state code (controller -> decoder)
//   memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst,
//   pcsrc[1:0], alusrcb[1:0], irwrite[3:0], pcwrite, branch, aluop[1:0]
//            : registered datapath control strobes (decoder -> datapath)
// Modports:
//   master : controller/datapath side, drives state, receives strobes
//   slave  : output decoder side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface mips_ctrl_output_decoder_if;
    logic [3:0] state;
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [3:0] irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    modport master (
        output state,
        input  memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst,
        input  pcsrc, alusrcb, irwrite, pcwrite, branch, aluop
    );

    modport slave (
        input  state,
        output memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst,
        output pcsrc, alusrcb, irwrite, pcwrite, branch, aluop
    );
endinterface

// File: rtl/mips_ctrl_output_decoder_decode_comb.sv
// ---------------------------------------------------------------------------
// mips_ctrl_decode_comb
// Pure combinational map from controller state code to datapath strobes.
//   state_i : 4-bit controller state code
//   ctrl_o  : decoded control bundle (ctrl_t); unused codes give all zeros
// Build option: define MIPS_CTRL_ADDI_EN to decode ADDIWR (state 14) as a
// register write of the ALU result into rt; otherwise state 14 is unused.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mips_ctrl_decode_comb
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_ONE;
                ctrl_o.pcwrite = 1'b1;
                // Each fetch cycle loads one byte of the 32-bit instruction.
                case (state_i)
                    FETCH1:  ctrl_o.irwrite = IRWRITE_B0;
                    FETCH2:  ctrl_o.irwrite = IRWRITE_B1;
                    FETCH3:  ctrl_o.irwrite = IRWRITE_B2;
                    default: ctrl_o.irwrite = IRWRITE_B3;
                endcase
            end
            DECODE: begin
                ctrl_o.alusrcb = ALUSRCB_BRIMM;
            end
            MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_IMM;
            end
            LBRD: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            LBWR: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            SBWR: begin
                ctrl_o.memwrite = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            RTYPEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            RTYPEWR: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.regdst   = 1'b1;
            end
            BEQEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_REGB;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.branch  = 1'b1;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
            end
            JEX: begin
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.pcsrc   = PCSRC_JUMP;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ADDIWR: begin
                // Write the ALU result into rt.
                ctrl_o.regwrite = 1'b1;
                ctrl_o.regdst   = 1'b0;
                ctrl_o.memtoreg = 1'b0;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_output_decoder.sv
// ---------------------------------------------------------------------------
// mips_ctrl_output_decoder
// Output-decode stage of the multicycle 8-bit MIPS controller. Decodes the
// controller state code and registers the result so the datapath strobes
// are glitch-free; strobes follow state with one cycle of latency.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset, clears every strobe
//   bus     : mips_ctrl_output_decoder_if.slave (state in, strobes out)
// Build option: MIPS_CTRL_ADDI_EN enables the ADDIWR decode (see decoder).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mips_ctrl_output_decoder
    import mips_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset_n,
    mips_ctrl_output_decoder_if.slave      bus
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    mips_ctrl_decode_comb u_decode (
        .state_i (bus.state),
        .ctrl_o  (ctrl_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.memread  = ctrl_q.memread;
    assign bus.memwrite = ctrl_q.memwrite;
    assign bus.alusrca  = ctrl_q.alusrca;
    assign bus.memtoreg = ctrl_q.memtoreg;
    assign bus.iord     = ctrl_q.iord;
    assign bus.regwrite = ctrl_q.regwrite;
    assign bus.regdst   = ctrl_q.regdst;
    assign bus.pcsrc    = ctrl_q.pcsrc;
    assign bus.alusrcb  = ctrl_q.alusrcb;
    assign bus.irwrite  = ctrl_q.irwrite;
    assign bus.pcwrite  = ctrl_q.pcwrite;
    assign bus.branch   = ctrl_q.branch;
    assign bus.aluop    = ctrl_q.aluop;

endmodule

// File: tb/tb_mips_ctrl_output_decoder.sv
// ---------------------------------------------------------------------------
// tb_mips_ctrl_output_decoder
// Directed bench for mips_ctrl_output_decoder. Expected strobes are written
// out by hand from the decode table. Define MIPS_CTRL_ADDI_EN for both the
// bench and the RTL to exercise the ADDIWR decode.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_ctrl_output_decoder;
    import mips_ctrl_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   n_vec   = 0;
    int   n_err   = 0;

    mips_ctrl_output_decoder_if bus ();

    mips_ctrl_output_decoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Field order: memread memwrite alusrca memtoreg iord regwrite regdst
    //              pcsrc alusrcb irwrite pcwrite branch aluop
    function automatic ctrl_t expect_for(input int s);
        ctrl_t e;
        e = '0;
        case (s)
            1:  e = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,4'b0001,1'b1,1'b0,2'b00};
            2:  e = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,4'b0010,1'b1,1'b0,2'b00};
            3:  e = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,4'b0100,1'b1,1'b0,2'b00};
            4:  e = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,4'b1000,1'b1,1'b0,2'b00};
            5:  e = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,4'b0000,1'b0,1'b0,2'b00};
            6:  e = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,4'b0000,1'b0,1'b0,2'b00};
            7:  e = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,4'b0000,1'b0,1'b0,2'b00};
            8:  e = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0000,1'b0,1'b0,2'b00};
            9:  e = {1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,4'b0000,1'b0,1'b0,2'b00};
            10: e = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0000,1'b0,1'b0,2'b10};
            11: e = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,4'b0000,1'b0,1'b0,2'b00};
            12: e = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,4'b0000,1'b0,1'b1,2'b01};
            13: e = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,4'b0000,1'b1,1'b0,2'b00};
`ifdef MIPS_CTRL_ADDI_EN
            14: e = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0000,1'b0,1'b0,2'b00};
`endif
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic ctrl_t observed();
        ctrl_t o;
        o = {bus.memread, bus.memwrite, bus.alusrca, bus.memtoreg, bus.iord,
             bus.regwrite, bus.regdst, bus.pcsrc, bus.alusrcb, bus.irwrite,
             bus.pcwrite, bus.branch, bus.aluop};
        return o;
    endfunction

    task automatic check(input string tag, input ctrl_t exp);
        ctrl_t obs;
        obs = observed();
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %05h required %05h", tag, obs, exp);
        end
        n_vec++;
        assert ($onehot0(obs.irwrite) && !(obs.memread && obs.memwrite) &&
                !(obs.pcwrite && obs.branch)) else begin
            n_err++;
            $error("FAIL %s_invariant: observed %05h required onehot0/exclusive strobes", tag, obs);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Change state on the falling edge, sample 1 ns after the next rising edge.
    task automatic step(input int s, input string tag);
        @(negedge clk);
        bus.state = 4'(s);
        @(posedge clk);
        #1;
        check(tag, expect_for(s));
    endtask

    initial begin
        // Reset asserted with FETCH4 on the bus, before any clock edge.
        reset_n   = 1'b0;
        bus.state = 4'd4;
        #1;
        check("reset_before_edge", '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", '0);

        // Release away from the clock edge; first edge loads FETCH4.
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_fetch4", expect_for(4));

        step(4, "fetch4");
        step(5, "decode");
        step(6, "memadr");
        step(10, "rtypeex");

        // Sweep every state code.
        for (int s = 0; s < 16; s++) begin
            step(s, $sformatf("sweep_s%0d", s));
        end

        step(12, "beqex");
        check_bit("beqex_branch", bus.branch, 1'b1);
        check_bit("beqex_pcwrite", bus.pcwrite, 1'b0);
        step(13, "jex");
        check_bit("jex_pcwrite", bus.pcwrite, 1'b1);
        check_bit("jex_branch", bus.branch, 1'b0);

        step(14, "addiwr");
`ifdef MIPS_CTRL_ADDI_EN
        check_bit("addiwr_regwrite", bus.regwrite, 1'b1);
`else
        check_bit("addiwr_regwrite", bus.regwrite, 1'b0);
`endif

        // Asynchronous clear mid-sequence while LBRD is registered.
        step(7, "lbrd");
        #2;
        reset_n = 1'b0;
        #1;
        check("async_clear", '0);
        @(negedge clk);
        check("async_clear_held", '0);
        reset_n = 1'b1;
        step(9, "sbwr_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute bound on the run.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish required finish by 20000ns");
        $fatal(1, "timeout");
    end

endmodule
